vend_change_dispenser: RTL and testbench

- Back-end actuator block for the vending controller. It consumes the controller's per-transaction outputs: the vend strobe z and the owed-change code change[1:0].
- It queues each transaction and drives the product-release solenoid and the coin hopper with timed pulses: one product pulse, then one coin pulse per unit of change owed.
- It reports backlog, queue overflow and hopper-empty fault to the system.

---
 rtl/vend_change_dispenser.sv | 173 +++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vend_change_dispenser
// Brief    : Queues vend transactions and drives timed product and coin pulses.
// Revision : 1.0
// ============================================================================
module vend_change_dispenser #(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2,
   parameter int DEPTH   = 4,
   parameter int OW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          z,
   input  logic [1:0]    change,
   input  logic          hopper_empty,
   output logic          product_pulse,
   output logic          coin_pulse,
   output logic          busy,
   output logic [OW-1:0] owed,
   output logic          req_drop,
   output logic          err_hopper
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(PULSE_W + GAP_W + 1);
   localparam logic [CW-1:0] c_full       = CW'(DEPTH);
   localparam logic [TW-1:0] c_pulse_last = TW'(PULSE_W - 1);
   localparam logic [TW-1:0] c_gap_last   = TW'(GAP_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PROD  = 3'd1,
      S_PGAP  = 3'd2,
      S_COIN  = 3'd3,
      S_CGAP  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [1:0]      coins_left_q, coins_left_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   owed_q, owed_d;
   logic            product_pulse_q, product_pulse_d;
   logic            coin_pulse_q, coin_pulse_d;
   logic            err_hopper_q, err_hopper_d;
   logic            req_drop_q, req_drop_d;
   logic [1:0]      fifo_q [DEPTH];
   logic            do_push, do_pop, coin_done;

   always_comb begin
      state_d         = state_q;
      tmr_d           = tmr_q;
      coins_left_d    = coins_left_q;
      product_pulse_d = product_pulse_q;
      coin_pulse_d    = coin_pulse_q;
      err_hopper_d    = err_hopper_q;
      do_pop          = 1'b0;
      coin_done       = 1'b0;
      // Fullness is judged on the registered count, so a same-edge pop never rescues a push.
      do_push         = z && (count_q != c_full);
      req_drop_d      = z && (count_q == c_full);

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               do_pop          = 1'b1;
               coins_left_d    = fifo_q[rd_ptr_q];
               product_pulse_d = 1'b1;
               tmr_d           = '0;
               state_d         = S_PROD;
            end
         end
         S_PROD: begin
            if (tmr_q == c_pulse_last) begin
               product_pulse_d = 1'b0;
               tmr_d           = '0;
               state_d         = S_PGAP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_PGAP, S_CGAP: begin
            if (tmr_q == c_gap_last) begin
               tmr_d = '0;
               if (coins_left_q == 2'd0) begin
                  state_d = S_IDLE;
               end else if (hopper_empty) begin
                  err_hopper_d = 1'b1;
                  state_d      = S_FAULT;
               end else begin
                  coin_pulse_d = 1'b1;
                  state_d      = S_COIN;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_COIN: begin
            if (tmr_q == c_pulse_last) begin
               coin_pulse_d = 1'b0;
               coin_done    = 1'b1;
               coins_left_d = coins_left_q - 2'd1;
               tmr_d        = '0;
               state_d      = S_CGAP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_FAULT: begin
            if (!hopper_empty) begin
               err_hopper_d = 1'b0;
               coin_pulse_d = 1'b1;
               tmr_d        = '0;
               state_d      = S_COIN;
            end
         end
         default: begin
            product_pulse_d = 1'b0;
            coin_pulse_d    = 1'b0;
            err_hopper_d    = 1'b0;
            tmr_d           = '0;
            state_d         = S_IDLE;
         end
      endcase

      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      owed_d   = owed_q + (do_push ? OW'(change) : '0) - OW'(coin_done);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         tmr_q           <= '0;
         coins_left_q    <= '0;
         count_q         <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         owed_q          <= '0;
         product_pulse_q <= 1'b0;
         coin_pulse_q    <= 1'b0;
         err_hopper_q    <= 1'b0;
         req_drop_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q         <= state_d;
         tmr_q           <= tmr_d;
         coins_left_q    <= coins_left_d;
         count_q         <= count_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         owed_q          <= owed_d;
         product_pulse_q <= product_pulse_d;
         coin_pulse_q    <= coin_pulse_d;
         err_hopper_q    <= err_hopper_d;
         req_drop_q      <= req_drop_d;
         if (do_push) fifo_q[wr_ptr_q] <= change;
      end
   end

   assign product_pulse = product_pulse_q;
   assign coin_pulse    = coin_pulse_q;
   assign err_hopper    = err_hopper_q;
   assign req_drop      = req_drop_q;
   assign owed          = owed_q;
   assign busy          = (state_q != S_IDLE) | (count_q != '0);
endmodule
`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_change_dispenser
// Brief    : Timestamp-schedule model plus directed vectors for the dispenser.
// Revision : 1.0
// ============================================================================
module tb_vend_change_dispenser;
   localparam int PULSE_W = 4;
   localparam int GAP_W   = 2;
   localparam int DEPTH   = 4;
   localparam int OW      = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          z = 1'b0;
   logic [1:0]    change = 2'd0;
   logic          hopper_empty = 1'b0;
   logic          product_pulse, coin_pulse, busy, req_drop, err_hopper;
   logic [OW-1:0] owed;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: pending queue plus absolute edge timestamps of the current pulses.
   int mt = 0;
   int mq[$];
   bit m_active = 1'b0, m_fault = 1'b0, m_coin = 1'b0, m_drop = 1'b0;
   int m_left = 0, m_owed = 0, prod_start = -1000, coin_start = -1000, dec_t = 0;
   int pre_n;

   int   e0 = 0;
   int   np = 0, nc = 0;
   logic pp = 1'b0, cp = 1'b0;

   vend_change_dispenser #(
      .PULSE_W(PULSE_W), .GAP_W(GAP_W), .DEPTH(DEPTH), .OW(OW)
   ) dut (
      .clk(clk), .rst(rst), .z(z), .change(change), .hopper_empty(hopper_empty),
      .product_pulse(product_pulse), .coin_pulse(coin_pulse), .busy(busy),
      .owed(owed), .req_drop(req_drop), .err_hopper(err_hopper)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at model edge %0d: got %0d expected %0d", nm, mt, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         m_active = 1'b0; m_fault = 1'b0; m_coin = 1'b0; m_drop = 1'b0;
         m_left = 0; m_owed = 0; prod_start = -1000; coin_start = -1000; dec_t = 0;
      end else begin
         mt++;
         pre_n = mq.size();
         if (!m_active) begin
            if (pre_n > 0) begin
               m_left     = mq.pop_front();
               m_active   = 1'b1;
               prod_start = mt;
               dec_t      = mt + PULSE_W + GAP_W;
            end
         end else if (m_fault) begin
            if (!hopper_empty) begin
               m_fault = 1'b0; m_coin = 1'b1; coin_start = mt; dec_t = mt + PULSE_W + GAP_W;
            end
         end else if (m_coin) begin
            if (mt == coin_start + PULSE_W) begin
               m_coin = 1'b0; m_left--; m_owed--;
            end
         end else if (mt == dec_t) begin
            if (m_left == 0) m_active = 1'b0;
            else if (hopper_empty) m_fault = 1'b1;
            else begin
               m_coin = 1'b1; coin_start = mt; dec_t = mt + PULSE_W + GAP_W;
            end
         end
         m_drop = 1'b0;
         if (z) begin
            if (pre_n < DEPTH) begin
               mq.push_back(int'(change));
               m_owed += int'(change);
            end else begin
               m_drop = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("product_pulse", {31'd0, product_pulse}, {31'd0, (mt >= prod_start) && (mt < prod_start + PULSE_W)});
      chk("coin_pulse", {31'd0, coin_pulse}, {31'd0, m_coin});
      chk("err_hopper", {31'd0, err_hopper}, {31'd0, m_fault});
      chk("req_drop", {31'd0, req_drop}, {31'd0, m_drop});
      chk("busy", {31'd0, busy}, {31'd0, m_active || (mq.size() != 0)});
      chk("owed", {28'd0, owed}, m_owed);
      chk("pulse_exclusive", {31'd0, product_pulse & coin_pulse}, 32'd0);
   end

   task automatic vend(input logic [1:0] c);
      @(negedge clk);
      z = 1'b1; change = c; e0 = mt + 1;
      @(negedge clk);
      z = 1'b0; change = 2'd0;
   endtask

   task automatic goto(input int k);
      int g;
      g = 0;
      while (mt < e0 + k && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (mt != e0 + k) begin
         n_fail++;
         $display("FAIL goto_edge_%0d: at model edge %0d expected %0d", k, mt, e0 + k);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (product_pulse && !pp) np++;
      if (coin_pulse && !cp) nc++;
      pp = product_pulse;
      cp = coin_pulse;
   endtask

   task automatic clr_cnt();
      np = 0; nc = 0; pp = 1'b0; cp = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int g;
      g = 0;
      do begin
         tick();
         g++;
      end while (busy && g < lim);
      if (busy) begin
         n_fail++;
         $display("FAIL idle_timeout: busy still %0d after %0d cycles required 0", busy, lim);
      end
   endtask

   initial begin
      // Reset held with a vend request present
      #1 rst = 1'b1; z = 1'b1; change = 2'd3;
      repeat (3) begin
         @(negedge clk);
         chk("rst_owed", {28'd0, owed}, 32'd0);
         chk("rst_product", {31'd0, product_pulse}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_drop", {31'd0, req_drop}, 32'd0);
      end
      rst = 1'b0; z = 1'b0; change = 2'd0;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // Single vend with two coins owed
      vend(2'd2);
      chk("sv_owed_e0", {28'd0, owed}, 32'd2);
      chk("sv_prod_e0", {31'd0, product_pulse}, 32'd0);
      goto(1);  chk("sv_prod_e1", {31'd0, product_pulse}, 32'd1);
      goto(4);  chk("sv_prod_e4", {31'd0, product_pulse}, 32'd1);
      goto(5);  chk("sv_prod_e5", {31'd0, product_pulse}, 32'd0);
      goto(6);  chk("sv_coin_e6", {31'd0, coin_pulse}, 32'd0);
      goto(7);  chk("sv_coin_e7", {31'd0, coin_pulse}, 32'd1);
      goto(10); chk("sv_owed_e10", {28'd0, owed}, 32'd2);
      goto(11); chk("sv_coin_e11", {31'd0, coin_pulse}, 32'd0);
                chk("sv_owed_e11", {28'd0, owed}, 32'd1);
      goto(13); chk("sv_coin_e13", {31'd0, coin_pulse}, 32'd1);
      goto(17); chk("sv_owed_e17", {28'd0, owed}, 32'd0);
                chk("sv_busy_e17", {31'd0, busy}, 32'd1);
      goto(18); chk("sv_busy_e18", {31'd0, busy}, 32'd1);
      goto(19); chk("sv_busy_e19", {31'd0, busy}, 32'd0);

      // Zero change: product pulse and gap only
      clr_cnt();
      vend(2'd0);
      goto(1); chk("zc_prod_e1", {31'd0, product_pulse}, 32'd1);
      goto(5); chk("zc_prod_e5", {31'd0, product_pulse}, 32'd0);
      goto(6); chk("zc_busy_e6", {31'd0, busy}, 32'd1);
      goto(7); chk("zc_busy_e7", {31'd0, busy}, 32'd0);
               chk("zc_coin_e7", {31'd0, coin_pulse}, 32'd0);

      // Overflow: six consecutive requests of three coins
      clr_cnt();
      @(negedge clk);
      e0 = mt + 1;
      for (int i = 0; i < 6; i++) begin
         z = 1'b1; change = 2'd3;
         tick();
         chk("ovf_drop", {31'd0, req_drop}, (i == 5) ? 32'd1 : 32'd0);
         if (i == 4) chk("ovf_owed_peak", {28'd0, owed}, 32'd15);
      end
      z = 1'b0; change = 2'd0;
      wait_idle(400);
      chk("ovf_products", np, 32'd5);
      chk("ovf_coins", nc, 32'd15);
      chk("ovf_owed_end", {28'd0, owed}, 32'd0);

      // Hopper runs dry during the first coin gap
      vend(2'd3);
      goto(11); hopper_empty = 1'b1;
      goto(13); chk("hf_err_e13", {31'd0, err_hopper}, 32'd1);
                chk("hf_coin_e13", {31'd0, coin_pulse}, 32'd0);
                chk("hf_owed_e13", {28'd0, owed}, 32'd2);
      goto(16); chk("hf_err_e16", {31'd0, err_hopper}, 32'd1);
                chk("hf_owed_e16", {28'd0, owed}, 32'd2);
      hopper_empty = 1'b0;
      clr_cnt();
      wait_idle(200);
      chk("hf_coins_after", nc, 32'd2);
      chk("hf_err_end", {31'd0, err_hopper}, 32'd0);
      chk("hf_owed_end", {28'd0, owed}, 32'd0);

      // Back-to-back: second request lands in the first one's coin gap
      vend(2'd1);
      goto(11);
      z = 1'b1; change = 2'd0;
      @(negedge clk);
      z = 1'b0;
      goto(13); chk("bb_prod_e13", {31'd0, product_pulse}, 32'd0);
                chk("bb_busy_e13", {31'd0, busy}, 32'd1);
      goto(14); chk("bb_prod_e14", {31'd0, product_pulse}, 32'd1);
                chk("bb_coin_e14", {31'd0, coin_pulse}, 32'd0);
      wait_idle(200);

      // Asynchronous reset in the middle of a coin pulse
      vend(2'd3);
      goto(8);
      chk("ar_coin_before", {31'd0, coin_pulse}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_coin_async", {31'd0, coin_pulse}, 32'd0);
      chk("ar_busy_async", {31'd0, busy}, 32'd0);
      chk("ar_owed_async", {28'd0, owed}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clr_cnt();
      repeat (30) tick();
      chk("ar_no_product", np, 32'd0);
      chk("ar_no_coin", nc, 32'd0);
      chk("ar_busy_end", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
